// File: rtl/mem_arbiter.sv
// mem_arbiter: per-core instruction/data arbiter onto one RAM port; data grants stay locked while requested.
// Define ARB_RR_EN for round-robin data arbitration (default: fixed core-0 priority).
module mem_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [31:0]           iload,
    output logic [31:0]           dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    state_t state, state_n;
    logic owner, owner_n;
    logic [1:0] dq, iq;
    logic d_pick, i_pick, o_dr, o_dw, o_ir, done;

    assign dq = 2'(dREN | dWEN);
    assign iq = 2'(iREN);
    assign i_pick = !iq[0];
    assign o_dr = dREN[owner];
    assign o_dw = dWEN[owner];
    assign o_ir = iREN[owner];

`ifdef ARB_RR_EN
    logic rr_ptr;
    assign d_pick = (rr_ptr && dq[1]) || !dq[0];
    // Pointer moves past the core that just finished its data grant.
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            rr_ptr <= 1'b0;
        else if (state == GRANT_D && state_n == IDLE)
            rr_ptr <= ~owner;
`else
    assign d_pick = !dq[0];
`endif

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state <= IDLE;
            owner <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            err   <= err | (state != IDLE && ramstate == ERROR);
        end

    always_comb begin
        state_n = state;
        owner_n = owner;
        if (state == IDLE) begin
            state_n = |dq ? GRANT_D : |iq ? GRANT_I : IDLE;
            owner_n = |dq ? d_pick : |iq ? i_pick : 1'b0;
        end else if (state == GRANT_D)
            state_n = (o_dr || o_dw) ? GRANT_D : IDLE;
        else if (state == GRANT_I)
            state_n = (o_ir && ramstate != ACCESS) ? GRANT_I : IDLE;
        else
            state_n = IDLE;
    end

    always_comb begin
        ramWEN   = state == GRANT_D && o_dw;
        ramREN   = (state == GRANT_D && o_dr && !o_dw) || (state == GRANT_I && o_ir);
        ramaddr  = state == GRANT_D ? daddr[owner] : state == GRANT_I ? iaddr[owner] : 32'd0;
        ramstore = state == GRANT_D ? dstore[owner] : 32'd0;
        done     = (ramREN || ramWEN) && ramstate == ACCESS;
        iwait    = '1;
        dwait    = '1;
        if (state == GRANT_I)
            iwait[owner] = !done;
        if (state == GRANT_D)
            dwait[owner] = !done;
    end

    assign iload    = ramload;
    assign dload    = ramload;
    assign busy     = state != IDLE;
    assign grant_id = state == IDLE ? 2'b00 : {state == GRANT_D, owner};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus directed error, reset and data-arbitration sequences.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    logic [1:0] iREN, dREN, dWEN, iwait, dwait;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic ramREN, ramWEN, busy, err;
    logic [1:0] ramstate, grant_id;
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    typedef struct {
        logic [1:0]  ir, dr, dw, rs;
        logic [31:0] da;
        logic [1:0]  gid;
        logic        bz, ren, wen, ad;
        logic [31:0] addr, store;
        logic [1:0]  iw, dwt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] ir, dr, dw, rs, logic [31:0] da, logic [1:0] gid,
                                logic bz, ren, wen, ad, logic [31:0] addr, store,
                                logic [1:0] iw, dwt);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs; v.da = da; v.gid = gid;
        v.bz = bz; v.ren = ren; v.wen = wen; v.ad = ad; v.addr = addr; v.store = store;
        v.iw = iw; v.dwt = dwt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    logic [1:0] rr_exp [4];
    int o;

    initial begin
        nRST = 1'b0;
        iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11; ramstate = 2'd2;
        ramload = 32'hCAFE0001;
        iaddr[0] = 32'h100; iaddr[1] = 32'h200;
        daddr[0] = 32'h40;  daddr[1] = 32'h300;
        dstore[0] = 32'h5555; dstore[1] = 32'h1234;

        // Data-read burst with BUSY wait states, then same-cycle D/I contention, locked burst, write-wins, iREN drop.
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'd1, 32'h40, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'd1, 32'h40, 2'd2, 1, 1, 0, 1, 32'h40, 32'h5555, 2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'd1, 32'h40, 2'd2, 1, 1, 0, 1, 32'h40, 32'h5555, 2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'd2, 32'h40, 2'd2, 1, 1, 0, 1, 32'h40, 32'h5555, 2'b11, 2'b10));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h40, 2'd2, 1, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b10, 2'd0, 32'h40, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b10, 2'd2, 32'h40, 2'd3, 1, 0, 1, 1, 32'h300, 32'h1234, 2'b11, 2'b01));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'd0, 32'h40, 2'd3, 1, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'd0, 32'h40, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'd2, 32'h40, 2'd0, 1, 1, 0, 1, 32'h100, 32'h0,   2'b10, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h40, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, 2'd0, 32'h80, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, 2'd2, 32'h80, 2'd2, 1, 1, 0, 1, 32'h80, 32'h5555, 2'b11, 2'b10));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, 2'd2, 32'h84, 2'd2, 1, 1, 0, 1, 32'h84, 32'h5555, 2'b11, 2'b10));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'd0, 32'h84, 2'd2, 1, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'd2, 32'h84, 2'd1, 1, 1, 0, 1, 32'h200, 32'h0,   2'b01, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 2'b01, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 2'b01, 2'd2, 32'h84, 2'd2, 1, 0, 1, 1, 32'h84, 32'h5555, 2'b11, 2'b10));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h84, 2'd2, 1, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'd1, 32'h84, 2'd0, 1, 1, 0, 1, 32'h100, 32'h0,   2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 1, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h84, 2'd0, 0, 0, 0, 1, 32'h0,  32'h0,    2'b11, 2'b11));

        // Reset state with every request asserted.
        #3;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst gid", 32'(grant_id), 32'd0);
        chk("rst strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst iwait", 32'(iwait), 32'h3);
        chk("rst dwait", 32'(dwait), 32'h3);
        chk("rst err", 32'(err), 32'd0);
        iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ramstate = 2'd0;
        @(negedge CLK);
        nRST = 1'b1;
        cyc();

        foreach (tbl[k]) begin
            iREN = tbl[k].ir; dREN = tbl[k].dr; dWEN = tbl[k].dw;
            ramstate = tbl[k].rs; daddr[0] = tbl[k].da;
            @(negedge CLK);
            chk($sformatf("row%0d gid", k), 32'(grant_id), 32'(tbl[k].gid));
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].bz));
            chk($sformatf("row%0d ramREN", k), 32'(ramREN), 32'(tbl[k].ren));
            chk($sformatf("row%0d ramWEN", k), 32'(ramWEN), 32'(tbl[k].wen));
            chk($sformatf("row%0d iwait", k), 32'(iwait), 32'(tbl[k].iw));
            chk($sformatf("row%0d dwait", k), 32'(dwait), 32'(tbl[k].dwt));
            chk($sformatf("row%0d dload", k), dload, 32'hCAFE0001);
            if (tbl[k].ad) begin
                chk($sformatf("row%0d ramaddr", k), ramaddr, tbl[k].addr);
                chk($sformatf("row%0d ramstore", k), ramstore, tbl[k].store);
            end
            cyc();
        end

        // ERROR while granted: sticky err, owner stalled, cleared only by reset.
        dREN = 2'b10; ramstate = 2'd3;
        @(negedge CLK);
        chk("err idle", 32'(err), 32'd0);
        cyc();
        @(negedge CLK);
        chk("err gid", 32'(grant_id), 32'd3);
        chk("err pre", 32'(err), 32'd0);
        chk("err dwait", 32'(dwait), 32'h3);
        cyc();
        ramstate = 2'd0;
        @(negedge CLK);
        chk("err set", 32'(err), 32'd1);
        cyc();
        @(negedge CLK);
        chk("err held", 32'(err), 32'd1);
        chk("err still granted", 32'(busy), 32'd1);
        nRST = 1'b0;
        #1;
        chk("err cleared", 32'(err), 32'd0);
        chk("err rst busy", 32'(busy), 32'd0);
        dREN = 2'b00;
        @(negedge CLK);
        nRST = 1'b1;
        cyc();

        // Reset falling mid-grant must kill strobes immediately.
        dREN = 2'b01; dWEN = 2'b01; ramstate = 2'd2;
        cyc();
        @(negedge CLK);
        chk("mid pre ramWEN", 32'(ramWEN), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("mid ramREN", 32'(ramREN), 32'd0);
        chk("mid ramWEN", 32'(ramWEN), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid iwait", 32'(iwait), 32'h3);
        chk("mid dwait", 32'(dwait), 32'h3);
        dREN = 2'b00; dWEN = 2'b00;
        @(negedge CLK);
        nRST = 1'b1;
        cyc();

        // Two cores re-requesting data continuously.
`ifdef ARB_RR_EN
        rr_exp = '{2'd2, 2'd3, 2'd2, 2'd3};
`else
        rr_exp = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
        dREN = 2'b11; ramstate = 2'd2;
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("data arb grant%0d", k), 32'(grant_id), 32'(rr_exp[k]));
            o = int'(rr_exp[k][0]);
            cyc();
            dREN[o] = 1'b0;
            cyc();
            dREN[o] = 1'b1;
            cyc();
        end
        dREN = 2'b00;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
